// File: rtl/cache_victim_sel_pkg.sv
// Shared cache package.
// Holds the associativity constants, the victim-selector FSM encoding, the
// default LFSR configuration and the lowest-set-bit priority function that
// the hit logic also uses.
package cache_victim_sel_pkg;

  localparam int CVS_WAYS       = 4;
  localparam int CVS_WAY_W      = $clog2(CVS_WAYS);
  localparam int CVS_MAX_WAYS   = 16;
  localparam int CVS_LFSR_WIDTH = 8;

  localparam logic [CVS_LFSR_WIDTH-1:0] CVS_LFSR_SEED = 8'h01;
  // Feedback taps for the 8-bit left-shifting LFSR: bits 7,5,4,1
  // (x^8 + x^6 + x^5 + x^2 + 1, maximal length).
  localparam logic [CVS_LFSR_WIDTH-1:0] CVS_LFSR_TAPS = 8'hB2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PICK  = 2'd1,
    OFFER = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Index of the lowest set bit of v; returns 0 when v is all zero.
  function automatic logic [3:0] lowest_set_idx(input logic [CVS_MAX_WAYS-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = CVS_MAX_WAYS - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cache_victim_sel_if.sv
// Request / victim bundle between the cache control FSM, the refill engine
// and the victim selector.
//
// Handshake rules: a request transfers on a rising edge where req_valid and
// req_ready are both high; the victim transfers on a rising edge where
// victim_valid and victim_ready are both high. A valid, once raised, stays
// high with stable payload until it transfers (or flush/reset abandons it).
// flush, refill_done are single-cycle level strobes sampled on clk.
//
// master: cache side (drives requests, accepts victims).
// slave : the victim selector.
// state is a debug view of the selector FSM.
interface cache_victim_sel_if
  import cache_victim_sel_pkg::*;
#(
  parameter int WAYS = CVS_WAYS
);
  localparam int WAY_W = $clog2(WAYS);

  logic             req_valid;
  logic             req_ready;
  logic [WAYS-1:0]  req_vbits;
  logic             flush;
  logic             victim_valid;
  logic             victim_ready;
  logic [WAY_W-1:0] victim_way;
  logic [WAYS-1:0]  victim_onehot;
  logic             victim_rand;
  logic             refill_done;
  logic             busy;
  state_t           state;

  modport master (
    output req_valid, req_vbits, flush, victim_ready, refill_done,
    input  req_ready, victim_valid, victim_way, victim_onehot, victim_rand,
           busy, state
  );

  modport slave (
    input  req_valid, req_vbits, flush, victim_ready, refill_done,
    output req_ready, victim_valid, victim_way, victim_onehot, victim_rand,
           busy, state
  );

endinterface

// File: rtl/cache_victim_sel_lfsr.sv
// Fibonacci LFSR, shifting left with the feedback bit entering at bit 0.
// Ports:
//   clk   - clock
//   reset - asynchronous active-high reset, loads seed
//   en    - advance one step this cycle
//   out   - current LFSR value
module lfsr #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] seed  = 8'h01,
  parameter logic [WIDTH-1:0] taps  = 8'hB2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] out
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out <= seed;
    end else if (en) begin
      out <= {out[WIDTH-2:0], ^(out & taps)};
    end
  end

endmodule

// File: rtl/cache_victim_sel.sv
// Victim-way selector for the set-associative cache.
// On a miss it captures the set's valid bits, picks the lowest invalid way or,
// when the set is full, a pseudo-random way from the internal LFSR, offers it
// to the refill engine and holds it until the refill completes.
// Ports:
//   clk   - clock, all state on rising edge
//   reset - asynchronous active-high reset
//   bus   - request/victim bundle (slave side), plus busy and debug state
module cache_victim_sel
  import cache_victim_sel_pkg::*;
#(
  parameter int                    WAYS       = CVS_WAYS,
  parameter int                    LFSR_WIDTH = CVS_LFSR_WIDTH,
  parameter logic [LFSR_WIDTH-1:0] SEED       = CVS_LFSR_SEED,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS  = CVS_LFSR_TAPS
) (
  input logic                clk,
  input logic                reset,
  cache_victim_sel_if.slave  bus
);

  localparam int WAY_W = $clog2(WAYS);

  state_t                  state_q;
  state_t                  state_d;
  logic [WAYS-1:0]         vbits_q;
  logic [WAY_W-1:0]        way_q;
  logic [WAYS-1:0]         onehot_q;
  logic                    rand_q;

  logic                    accept;
  logic                    load_victim;
  logic                    lfsr_en;
  logic [LFSR_WIDTH-1:0]   lfsr_out;
  logic                    all_valid;
  logic [CVS_MAX_WAYS-1:0] inv_bits;
  logic [3:0]              low_idx;
  logic [WAY_W-1:0]        pick_way;

  lfsr #(
    .WIDTH (LFSR_WIDTH),
    .seed  (SEED),
    .taps  (LFSR_TAPS)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (lfsr_en),
    .out   (lfsr_out)
  );

  // Invalid ways, widened to the priority function's fixed width.
  always_comb begin
    inv_bits           = '0;
    inv_bits[WAYS-1:0] = ~vbits_q;
  end

  assign all_valid = &vbits_q;
  assign low_idx   = lowest_set_idx(inv_bits);

  // WAYS is a power of two, so the modulo is just the low WAY_W LFSR bits.
  assign pick_way = all_valid ? WAY_W'(lfsr_out % LFSR_WIDTH'(WAYS))
                              : WAY_W'(low_idx);

  // req_ready is the only output with an input in its cone (flush).
  assign bus.req_ready    = (state_q == IDLE) && !bus.flush;
  assign accept           = bus.req_valid && bus.req_ready;
  assign bus.victim_valid = (state_q == OFFER);
  assign bus.busy         = (state_q != IDLE);
  assign bus.state        = state_q;
  assign bus.victim_way    = way_q;
  assign bus.victim_onehot = onehot_q;
  assign bus.victim_rand   = rand_q;

  always_comb begin
    state_d     = state_q;
    load_victim = 1'b0;
    lfsr_en     = 1'b0;
    if (bus.flush) begin
      // Abandon everything; in PICK this also suppresses the LFSR step.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (bus.req_valid) state_d = PICK;
        PICK: begin
          state_d     = OFFER;
          load_victim = 1'b1;
          // Only random picks consume LFSR values.
          lfsr_en     = all_valid;
        end
        OFFER: if (bus.victim_ready) state_d = HOLD;
        HOLD:  if (bus.refill_done) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vbits_q  <= '0;
      way_q    <= '0;
      onehot_q <= '0;
      rand_q   <= 1'b0;
    end else begin
      if (accept) begin
        vbits_q <= bus.req_vbits;
      end
      if (load_victim) begin
        way_q    <= pick_way;
        onehot_q <= WAYS'(1) << pick_way;
        rand_q   <= all_valid;
      end
    end
  end

endmodule

// File: tb/tb_cache_victim_sel.sv
module tb_cache_victim_sel;
  import cache_victim_sel_pkg::*;

  localparam int WAYS = 4;
  localparam int W    = 1 + WAYS + 2;  // {rand, onehot, way}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_victim_sel_if #(.WAYS(WAYS)) bus();

  cache_victim_sel #(
    .WAYS       (WAYS),
    .LFSR_WIDTH (8),
    .SEED       (8'h01)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- scoreboard ----------------
  int             n_checks = 0;
  int             n_fail   = 0;
  logic [W-1:0]   exp_q[$];
  logic [W-1:0]   cur_exp  = '0;
  logic           prev_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event did not occur as required at %0t", name, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops a fresh expectation whenever a victim is newly offered,
  // then holds every offered/held cycle to that expectation.
  task automatic monitor_loop;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 1'b0;
      end else begin
        if (bus.victim_valid && !prev_valid) begin
          if (exp_q.size() == 0) note_fail("unexpected_victim");
          else cur_exp = exp_q.pop_front();
        end
        if (bus.victim_valid || bus.state == HOLD)
          check("victim_fields", 32'({bus.victim_rand, bus.victim_onehot, bus.victim_way}),
                32'(cur_exp));
        prev_valid = bus.victim_valid;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic [3:0] vbits, input logic [1:0] way,
                        input logic [3:0] onehot, input logic rnd, input bit expect_victim);
    int t;
    t = 0;
    while (!bus.req_ready && t < 20) begin
      tick();
      t++;
    end
    if (!bus.req_ready) note_fail("req_ready_timeout");
    bus.req_valid = 1'b1;
    bus.req_vbits = vbits;
    if (expect_victim) exp_q.push_back({rnd, onehot, way});
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic complete;
    int t;
    t = 0;
    while (!bus.victim_valid && t < 20) begin
      tick();
      t++;
    end
    if (!bus.victim_valid) begin
      note_fail("victim_valid_timeout");
    end else begin
      bus.victim_ready = 1'b1;
      tick();
      bus.victim_ready = 1'b0;
      check("state_hold", 32'(bus.state), 32'(HOLD));
      check("valid_low_in_hold", 32'(bus.victim_valid), 32'd0);
      bus.refill_done = 1'b1;
      tick();
      bus.refill_done = 1'b0;
      check("idle_after_refill", 32'(bus.busy), 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, "_victim_valid"}, 32'(bus.victim_valid), 32'd0);
    check({tag, "_victim_way"}, 32'(bus.victim_way), 32'd0);
    check({tag, "_victim_onehot"}, 32'(bus.victim_onehot), 32'd0);
    check({tag, "_victim_rand"}, 32'(bus.victim_rand), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_state"}, 32'(bus.state), 32'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset            = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_vbits    = '0;
    bus.flush        = 1'b0;
    bus.victim_ready = 1'b0;
    bus.refill_done  = 1'b0;
    fork
      monitor_loop();
    join_none

    tick();
    tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // Invalid-way fill: 1011 -> way 2, latency 2 cycles.
    do_req(4'b1011, 2'd2, 4'b0100, 1'b0, 1'b1);
    check("pick_state", 32'(bus.state), 32'(PICK));
    check("pick_no_valid", 32'(bus.victim_valid), 32'd0);
    tick();
    check("latency2_valid", 32'(bus.victim_valid), 32'd1);
    check("latency2_way", 32'(bus.victim_way), 32'd2);
    complete();

    // Full sets: LFSR 01 -> 02 -> 05 -> 0A gives ways 1, 2, 1.
    do_req(4'b1111, 2'd1, 4'b0010, 1'b1, 1'b1);
    complete();
    do_req(4'b1111, 2'd2, 4'b0100, 1'b1, 1'b1);
    complete();
    do_req(4'b1111, 2'd1, 4'b0010, 1'b1, 1'b1);
    complete();

    // Stall in OFFER for 10 cycles; refill_done there is ignored. LFSR 0A -> way 2.
    do_req(4'b1111, 2'd2, 4'b0100, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 10; i++) begin
      bus.refill_done = (i == 4);
      tick();
      check("stall_state_offer", 32'(bus.state), 32'(OFFER));
      check("stall_valid", 32'(bus.victim_valid), 32'd1);
    end
    bus.refill_done = 1'b0;
    complete();

    // Flush in PICK on a full set: no victim, LFSR stays at 15 -> next way 1.
    do_req(4'b1111, 2'd0, 4'b0000, 1'b1, 1'b0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_state_idle", 32'(bus.state), 32'(IDLE));
    check("flush_no_valid", 32'(bus.victim_valid), 32'd0);
    tick();
    tick();
    check("flush_still_no_valid", 32'(bus.victim_valid), 32'd0);
    do_req(4'b1111, 2'd1, 4'b0010, 1'b1, 1'b1);
    complete();

    // Reset while in HOLD (LFSR 2B -> way 3), then reseeded LFSR -> way 1.
    do_req(4'b1111, 2'd3, 4'b1000, 1'b1, 1'b1);
    tick();
    bus.victim_ready = 1'b1;
    tick();
    bus.victim_ready = 1'b0;
    check("pre_reset_hold", 32'(bus.state), 32'(HOLD));
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    tick();
    tick();
    reset = 1'b0;
    tick();
    do_req(4'b1111, 2'd1, 4'b0010, 1'b1, 1'b1);
    complete();

    // req_valid together with flush in IDLE is not accepted.
    bus.req_valid = 1'b1;
    bus.req_vbits = 4'b0111;
    bus.flush     = 1'b1;
    #1;
    check("flush_blocks_ready", 32'(bus.req_ready), 32'd0);
    tick();
    check("flush_req_busy", 32'(bus.busy), 32'd0);
    check("flush_req_state", 32'(bus.state), 32'(IDLE));
    bus.flush = 1'b0;
    #1;
    check("ready_after_flush", 32'(bus.req_ready), 32'd1);
    exp_q.push_back({1'b0, 4'b1000, 2'd3});
    tick();
    bus.req_valid = 1'b0;
    check("accepted_after_flush", 32'(bus.state), 32'(PICK));
    complete();

    // Invalid fills between random picks must not step the LFSR (02 -> way 2, 05 -> way 1).
    do_req(4'b1111, 2'd2, 4'b0100, 1'b1, 1'b1);
    complete();
    do_req(4'b0000, 2'd0, 4'b0001, 1'b0, 1'b1);
    complete();
    do_req(4'b1110, 2'd0, 4'b0001, 1'b0, 1'b1);
    complete();
    do_req(4'b0111, 2'd3, 4'b1000, 1'b0, 1'b1);
    complete();
    do_req(4'b1111, 2'd1, 4'b0010, 1'b1, 1'b1);
    complete();

    tick();
    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "time limit");
  end

endmodule
